// File: rtl/ib_lut_page_loader_if.sv
// Write-side bus between the upstream LUT source, the page loader and the IB-CNU RAM.
// The master modport belongs to the upstream controller; the loader uses the slave modport.
interface ib_lut_page_loader_if #(
  parameter int unsigned ENTRY_ADDR      = 4,
  parameter int unsigned MULTI_FRAME_NUM = 2,
  parameter int unsigned BANK_NUM        = 2,
  parameter int unsigned LUT_PORT_SIZE   = 2,
  parameter int unsigned MAX_ITER        = 8
);
  localparam int unsigned FB = $clog2(MULTI_FRAME_NUM);
  localparam int unsigned DW = LUT_PORT_SIZE * BANK_NUM;
  localparam int unsigned IW = $clog2(MAX_ITER);

  logic                  start_load;
  logic [FB-1:0]         frame_sel;
  logic [DW-1:0]         lut_data_in;
  logic                  lut_valid_in;
  logic                  lut_ready_out;
  logic [ENTRY_ADDR-1:0] page_addr_ram;
  logic [DW-1:0]         ram_write_data_1;
  logic                  ib_ram_we;
  logic                  busy;
  logic                  load_done;
  logic [IW-1:0]         iter_cnt;

  modport master (
    output start_load, frame_sel, lut_data_in, lut_valid_in,
    input  lut_ready_out, page_addr_ram, ram_write_data_1, ib_ram_we, busy, load_done, iter_cnt
  );

  modport slave (
    input  start_load, frame_sel, lut_data_in, lut_valid_in,
    output lut_ready_out, page_addr_ram, ram_write_data_1, ib_ram_we, busy, load_done, iter_cnt
  );
endinterface

// File: rtl/ib_lut_page_loader.sv
// Streams one frame's worth of LUT pages into the IB-CNU RAM, one page per accepted beat,
// with a registered write port trailing each acceptance by a single cycle.
module ib_lut_page_loader #(
  parameter int unsigned ENTRY_ADDR      = 4,
  parameter int unsigned MULTI_FRAME_NUM = 2,
  parameter int unsigned BANK_NUM        = 2,
  parameter int unsigned LUT_PORT_SIZE   = 2,
  parameter int unsigned MAX_ITER        = 8
) (
  input  logic                 write_clk,
  input  logic                 rstn,
  ib_lut_page_loader_if.slave  bus
);
  localparam int unsigned FB       = $clog2(MULTI_FRAME_NUM);
  localparam int unsigned PW       = ENTRY_ADDR - FB;
  localparam int unsigned PAGE_NUM = 2 ** PW;
  localparam int unsigned DW       = LUT_PORT_SIZE * BANK_NUM;
  localparam int unsigned IW       = $clog2(MAX_ITER);

  localparam logic [PW-1:0] LastPage = PW'(PAGE_NUM - 1);
  localparam logic [IW-1:0] LastIter = IW'(MAX_ITER - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                state_q;
  logic [FB-1:0]         frame_q;
  logic [PW-1:0]         page_q;
  logic [ENTRY_ADDR-1:0] addr_q;
  logic [DW-1:0]         data_q;
  logic                  we_q;
  logic                  busy_q;
  logic                  done_q;
  logic [IW-1:0]         iter_q;

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      frame_q <= '0;
      page_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      iter_q  <= '0;
    end else begin
      // Write strobe and done flag are single-cycle pulses unless re-asserted below.
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start_load) begin
            frame_q <= bus.frame_sel;
            page_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (bus.lut_valid_in) begin
            we_q   <= 1'b1;
            addr_q <= {frame_q, page_q};
            data_q <= bus.lut_data_in;
            page_q <= page_q + PW'(1);
            if (page_q == LastPage) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              iter_q  <= (iter_q == LastIter) ? '0 : iter_q + IW'(1);
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.lut_ready_out    = (state_q == StLoad);
  assign bus.page_addr_ram    = addr_q;
  assign bus.ram_write_data_1 = data_q;
  assign bus.ib_ram_we        = we_q;
  assign bus.busy             = busy_q;
  assign bus.load_done        = done_q;
  assign bus.iter_cnt         = iter_q;
endmodule

// File: tb/tb_ib_lut_page_loader.sv
// Directed bench for ib_lut_page_loader: reset, full load, stalls, ignored start,
// iteration wrap with back-to-back loads, and reset abort.
module tb_ib_lut_page_loader;
  logic write_clk = 1'b0;
  logic rstn;
  int   errors = 0;
  int   checks = 0;

  always #5 write_clk = ~write_clk;

  ib_lut_page_loader_if bus ();

  ib_lut_page_loader dut (
    .write_clk (write_clk),
    .rstn      (rstn),
    .bus       (bus)
  );

  task automatic step;
    @(posedge write_clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    bus.start_load = 1'b0;
    bus.frame_sel = 1'b0;
    bus.lut_data_in = 4'h0;
    bus.lut_valid_in = 1'b0;
    step;
    step;
    checks++;
    if (bus.ib_ram_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", bus.ib_ram_we); end
    checks++;
    if (bus.page_addr_ram !== 4'h0) begin errors++; $display("FAIL rst_addr got %h want 0", bus.page_addr_ram); end
    checks++;
    if (bus.ram_write_data_1 !== 4'h0) begin errors++; $display("FAIL rst_data got %h want 0", bus.ram_write_data_1); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++;
    if (bus.load_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.load_done); end
    checks++;
    if (bus.iter_cnt !== 3'd0) begin errors++; $display("FAIL rst_iter got %0d want 0", bus.iter_cnt); end
    checks++;
    if (bus.lut_ready_out !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.lut_ready_out); end
    // Data offered while idle must not be consumed.
    rstn = 1'b1;
    bus.lut_valid_in = 1'b1;
    bus.lut_data_in = 4'h5;
    step;
    checks++;
    if (bus.lut_ready_out !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", bus.lut_ready_out); end
    checks++;
    if (bus.ib_ram_we !== 1'b0) begin errors++; $display("FAIL idle_we got %b want 0", bus.ib_ram_we); end
    bus.lut_valid_in = 1'b0;
  endtask

  task automatic test_full_load;
    bus.start_load = 1'b1;
    bus.frame_sel = 1'b1;
    step;
    bus.start_load = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b want 1", bus.busy); end
    checks++;
    if (bus.lut_ready_out !== 1'b1) begin errors++; $display("FAIL full_ready got %b want 1", bus.lut_ready_out); end
    for (int i = 0; i < 8; i++) begin
      bus.lut_valid_in = 1'b1;
      bus.lut_data_in = 4'(i);
      step;
      checks++;
      if (bus.ib_ram_we !== 1'b1 || bus.page_addr_ram !== 4'(8 + i) ||
          bus.ram_write_data_1 !== 4'(i)) begin
        errors++;
        $display("FAIL full_wr%0d got we=%b addr=%h data=%h want we=1 addr=%h data=%h", i,
                 bus.ib_ram_we, bus.page_addr_ram, bus.ram_write_data_1, 4'(8 + i), 4'(i));
      end
      checks++;
      if (bus.load_done !== (i == 7)) begin
        errors++; $display("FAIL full_done%0d got %b want %b", i, bus.load_done, i == 7);
      end
    end
    checks++;
    if (bus.lut_ready_out !== 1'b0) begin errors++; $display("FAIL done_ready got %b want 0", bus.lut_ready_out); end
    bus.lut_valid_in = 1'b0;
    step;
    checks++;
    if (bus.ib_ram_we !== 1'b0 || bus.load_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL full_idle got we=%b done=%b busy=%b want 0 0 0", bus.ib_ram_we,
               bus.load_done, bus.busy);
    end
    checks++;
    if (bus.iter_cnt !== 3'd1) begin errors++; $display("FAIL full_iter got %0d want 1", bus.iter_cnt); end
  endtask

  task automatic test_stalls;
    bus.start_load = 1'b1;
    bus.frame_sel = 1'b0;
    step;
    bus.start_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.lut_valid_in = 1'b1;
      bus.lut_data_in = 4'(15 - i);
      step;
      checks++;
      if (bus.ib_ram_we !== 1'b1 || bus.page_addr_ram !== 4'(i) ||
          bus.ram_write_data_1 !== 4'(15 - i)) begin
        errors++;
        $display("FAIL stall_wr%0d got we=%b addr=%h data=%h want we=1 addr=%h data=%h", i,
                 bus.ib_ram_we, bus.page_addr_ram, bus.ram_write_data_1, 4'(i), 4'(15 - i));
      end
      bus.lut_valid_in = 1'b0;
      if (i < 7) begin
        step;
        checks++;
        if (bus.ib_ram_we !== 1'b0 || bus.page_addr_ram !== 4'(i)) begin
          errors++;
          $display("FAIL stall_gap%0d got we=%b addr=%h want we=0 addr=%h", i, bus.ib_ram_we,
                   bus.page_addr_ram, 4'(i));
        end
      end
    end
    step;
    checks++;
    if (bus.iter_cnt !== 3'd2) begin errors++; $display("FAIL stall_iter got %0d want 2", bus.iter_cnt); end
  endtask

  task automatic test_ignored_start;
    bus.start_load = 1'b1;
    bus.frame_sel = 1'b1;
    step;
    bus.start_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.lut_valid_in = 1'b1;
      bus.lut_data_in = 4'(i ^ 5);
      if (i == 3) begin
        bus.start_load = 1'b1;
        bus.frame_sel = 1'b0;
      end
      step;
      bus.start_load = 1'b0;
      checks++;
      if (bus.ib_ram_we !== 1'b1 || bus.page_addr_ram !== 4'(8 + i) ||
          bus.ram_write_data_1 !== 4'(i ^ 5)) begin
        errors++;
        $display("FAIL ign_wr%0d got we=%b addr=%h data=%h want we=1 addr=%h data=%h", i,
                 bus.ib_ram_we, bus.page_addr_ram, bus.ram_write_data_1, 4'(8 + i), 4'(i ^ 5));
      end
    end
    bus.lut_valid_in = 1'b0;
    step;
    checks++;
    if (bus.iter_cnt !== 3'd3) begin errors++; $display("FAIL ign_iter got %0d want 3", bus.iter_cnt); end
  endtask

  task automatic test_iter_wrap;
    logic [2:0] exp_iter;
    rstn = 1'b0;
    step;
    rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      // Start is raised in the first idle cycle after the previous DONE.
      bus.start_load = 1'b1;
      bus.frame_sel = 1'(k % 2);
      step;
      bus.start_load = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_start%0d got busy=%b want 1", k, bus.busy); end
      for (int i = 0; i < 8; i++) begin
        bus.lut_valid_in = 1'b1;
        bus.lut_data_in = 4'(i);
        step;
      end
      checks++;
      if (bus.load_done !== 1'b1 || bus.page_addr_ram !== {1'(k % 2), 3'd7}) begin
        errors++;
        $display("FAIL wrap_done%0d got done=%b addr=%h want done=1 addr=%h", k, bus.load_done,
                 bus.page_addr_ram, {1'(k % 2), 3'd7});
      end
      bus.lut_valid_in = 1'b0;
      step;
      exp_iter = 3'((k + 1) % 8);
      checks++;
      if (bus.iter_cnt !== exp_iter) begin
        errors++; $display("FAIL wrap_iter%0d got %0d want %0d", k, bus.iter_cnt, exp_iter);
      end
    end
  endtask

  task automatic test_reset_abort;
    bus.start_load = 1'b1;
    bus.frame_sel = 1'b1;
    step;
    bus.start_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.lut_valid_in = 1'b1;
      bus.lut_data_in = 4'(i + 3);
      step;
    end
    rstn = 1'b0;
    step;
    checks++;
    if (bus.ib_ram_we !== 1'b0 || bus.page_addr_ram !== 4'h0 || bus.ram_write_data_1 !== 4'h0) begin
      errors++;
      $display("FAIL abort_wr got we=%b addr=%h data=%h want 0 0 0", bus.ib_ram_we,
               bus.page_addr_ram, bus.ram_write_data_1);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.load_done !== 1'b0 || bus.iter_cnt !== 3'd0 ||
        bus.lut_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%b done=%b iter=%0d ready=%b want 0 0 0 0", bus.busy,
               bus.load_done, bus.iter_cnt, bus.lut_ready_out);
    end
    rstn = 1'b1;
    bus.lut_valid_in = 1'b0;
    step;
    checks++;
    if (bus.ib_ram_we !== 1'b0) begin errors++; $display("FAIL abort_after got we=%b want 0", bus.ib_ram_we); end
    bus.start_load = 1'b1;
    bus.frame_sel = 1'b0;
    step;
    bus.start_load = 1'b0;
    bus.lut_valid_in = 1'b1;
    bus.lut_data_in = 4'hA;
    step;
    bus.lut_valid_in = 1'b0;
    checks++;
    if (bus.ib_ram_we !== 1'b1 || bus.page_addr_ram !== 4'h0 || bus.ram_write_data_1 !== 4'hA) begin
      errors++;
      $display("FAIL fresh_wr got we=%b addr=%h data=%h want we=1 addr=0 data=a", bus.ib_ram_we,
               bus.page_addr_ram, bus.ram_write_data_1);
    end
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_stalls;
    test_ignored_start;
    test_iter_wrap;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ib_lut_page_loader.md
IB_LUT_PAGE_LOADER -- requirements
Module: ib_lut_page_loader

Interface
REQ-001 Parameter ENTRY_ADDR, default 4: page-address width of the IB-CNU RAM write port; the MSB is the multi-frame offset.
REQ-002 Parameter MULTI_FRAME_NUM, default 2: frames held per RAM.
REQ-003 Parameter BANK_NUM, default 2: RAM banks per write word.
REQ-004 Parameter LUT_PORT_SIZE, default 2: bits per bank per write word.
REQ-005 Parameter MAX_ITER, default 8: iteration count; iter_cnt wraps at this value.
REQ-006 Derived constants: FB = $clog2(MULTI_FRAME_NUM); PW = ENTRY_ADDR-FB; PAGE_NUM = 2**PW; DW = LUT_PORT_SIZE*BANK_NUM; IW = $clog2(MAX_ITER).
REQ-007 write_clk  in  1  the single clock; all state updates on its rising edge.
REQ-008 rstn  in  1  reset; synchronous, active-low.
REQ-009 start_load  in  1  one-cycle request to begin a page load.
REQ-010 frame_sel  in  FB  target frame; sampled when start_load is accepted.
REQ-011 lut_data_in  in  DW  upstream LUT word; bank0 in the upper LUT_PORT_SIZE bits.
REQ-012 lut_valid_in  in  1  lut_data_in is valid.
REQ-013 lut_ready_out  out  1  loader accepts a word this cycle.
REQ-014 page_addr_ram  out  ENTRY_ADDR  {frame, page}; drives the RAM page_addr_ram write port.
REQ-015 ram_write_data_1  out  DW  write data to the RAM.
REQ-016 ib_ram_we  out  1  RAM write enable.
REQ-017 busy  out  1  high in state LOAD.
REQ-018 load_done  out  1  one-cycle pulse after the last page is written.
REQ-019 iter_cnt  out  IW  count of completed loads, modulo MAX_ITER.

Function
REQ-020 The FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-021 IDLE -> LOAD on start_load=1; frame_sel is latched and the page counter is cleared to 0.
REQ-022 LOAD: lut_ready_out=1 combinationally; a beat is accepted when lut_valid_in and lut_ready_out are both 1.
REQ-023 Each accepted beat SHALL, in the next cycle, produce ib_ram_we=1, page_addr_ram={latched frame, page counter value at acceptance} and ram_write_data_1=lut_data_in from acceptance; write latency is exactly 1 cycle.
REQ-024 A cycle in LOAD with lut_valid_in=0 SHALL produce ib_ram_we=0 in the next cycle; the page counter and address outputs hold their values.
REQ-025 The page counter SHALL increment by 1 per accepted beat; acceptance at page PAGE_NUM-1 moves the FSM to DONE and wraps the counter to 0.
REQ-026 DONE: lut_ready_out=0; load_done=1 for exactly one cycle; iter_cnt increments, wrapping MAX_ITER-1 -> 0; the FSM then returns to IDLE.
REQ-027 start_load SHALL be ignored in LOAD and in DONE; frame_sel and the counter are not disturbed.
REQ-028 Back-to-back operation: a start_load in the first IDLE cycle after DONE SHALL be accepted.
REQ-029 In IDLE and DONE, ib_ram_we=0 except for the final write that trails the last acceptance; that write SHALL coincide with the DONE cycle.
REQ-030 lut_ready_out SHALL be 0 in IDLE; upstream data presented while idle is not consumed.
REQ-031 ram_write_data_1 and page_addr_ram SHALL be registered; ib_ram_we SHALL never be high with an address outside the latched frame.

Reset
REQ-032 With rstn=0 at a clock edge: state=IDLE; page counter=0; latched frame=0; page_addr_ram=0; ram_write_data_1=0; ib_ram_we=0; busy=0; load_done=0; iter_cnt=0.
REQ-033 Reset mid-LOAD SHALL abort the load with no further writes; ib_ram_we is 0 in the cycle after the reset edge and iter_cnt is 0.

Verification
REQ-034 Scenario, full load: start_load with frame_sel=1, then 8 continuous beats 0x0..0x7 -> writes at addresses 0x8..0xF carrying data 0x0..0x7 on consecutive cycles; load_done pulses once; iter_cnt=1.
REQ-035 Scenario, stalls: lut_valid_in toggling 1,0,1,0 -> writes only on cycles after accepted beats; addresses contiguous 0x0..0x7 for frame 0; no duplicate or skipped pages.
REQ-036 Scenario, ignored start: start_load pulsed at page 3 with frame_sel=0 during a frame-1 load -> remaining addresses stay 0xB..0xF.
REQ-037 Scenario, iteration wrap: 8 consecutive loads -> iter_cnt sequence 1..7,0; start_load in the IDLE cycle after each DONE is accepted.
REQ-038 Scenario, reset abort: rstn=0 after 5 accepted beats -> ib_ram_we=0 from the next cycle, all outputs at reset values; a fresh load then starts at page 0.
